fifo_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/fifo_uart_tx_if.sv | 22 ++
 rtl/baud_tick_gen.sv | 36 +++
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 tb/tb_fifo_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
// Holds the state encoding and the parity helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic parity_bit(
    input logic [DATA_W-1:0] b,
    input logic              odd
  );
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the upstream synchronous FIFO.
// master = consumer that pops, slave = FIFO.
interface fifo_uart_tx_if;
  import uart_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and
// flags the last cycle of each serial bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends
// them as 8N1 / 8E1 / 8O1 UART frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tx_en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              tick;
  logic              clear;
  logic              go;
  logic              par;

  // Counter idles outside the serial states so
  // every START begins a full bit period.
  assign clear = (state_q == IDLE) ||
                 (state_q == REQ)  ||
                 (state_q == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  assign go  = tx_en && !fifo.fifo_empty;
  assign par = parity_bit(byte_q, PARITY_ODD != 0);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (go) state_d = REQ;
      REQ:  state_d = LOAD;
      LOAD: begin
        shreg_d = fifo.fifo_data;
        byte_d  = fifo.fifo_data;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ?
                      PARITY : STOP;
          end
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: begin
        if (tick) state_d = go ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and pop strobe are registered from the
  // next state so they align with the state reg.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par;
      default: tx_d = 1'b1;
    endcase
    rd_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
    end
  end

  assign tx              = tx_q;
  assign fifo.fifo_rd_en = rd_q;
  assign busy            = (state_q != IDLE);
  assign byte_done       = (state_q == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx.
// Instances: 0 = no parity, 1 = even, 2 = odd.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx_if if0 ();
  fifo_uart_tx_if if1 ();
  fifo_uart_tx_if if2 ();

  logic       tx_w   [3];
  logic       busy_w [3];
  logic       bd_w   [3];
  logic       rd_w   [3];
  logic [7:0] fd [3] = '{default: 8'h00};
  logic       fe [3] = '{default: 1'b1};

  logic [7:0] fq [3][$];
  logic [7:0] eq [3][$];

  int pops     [3] = '{default: 0};
  int done_cnt [3] = '{default: 0};
  int last_rd  [3] = '{default: 0};
  int st0 [$];
  int en0 [$];
  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  bit          cap   [3] = '{default: 1'b0};
  int          idx   [3];
  int          nbits [3];
  logic [10:0] expv  [3];
  logic [10:0] gotv  [3];
  bit          bad   [3];
  int          bdc   [3];

  fifo_uart_tx #(
    .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .fifo(if0), .tx(tx_w[0]), .busy(busy_w[0]),
    .byte_done(bd_w[0])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .fifo(if1), .tx(tx_w[1]), .busy(busy_w[1]),
    .byte_done(bd_w[1])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .fifo(if2), .tx(tx_w[2]), .busy(busy_w[2]),
    .byte_done(bd_w[2])
  );

  assign if0.fifo_data  = fd[0];
  assign if1.fifo_data  = fd[1];
  assign if2.fifo_data  = fd[2];
  assign if0.fifo_empty = fe[0];
  assign if1.fifo_empty = fe[1];
  assign if2.fifo_empty = fe[2];
  assign rd_w[0] = if0.fifo_rd_en;
  assign rd_w[1] = if1.fifo_rd_en;
  assign rd_w[2] = if2.fifo_rd_en;

  task automatic chk(
    input bit          ok,
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, req);
    end
  endtask

  // Line levels of a whole frame, bit 0 first.
  function automatic logic [10:0] frame_of(
    input logic [7:0] b,
    input int         g
  );
    logic [10:0] v;
    v      = '0;
    v[8:1] = b;
    if (g == 0) begin
      v[9] = 1'b1;
    end else begin
      v[9]  = (^b) ^ (g == 2);
      v[10] = 1'b1;
    end
    return v;
  endfunction

  // FIFO model: registered data_out and empty flag.
  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (rd_w[g]) begin
        pops[g]++;
        if (fq[g].size() == 0)
          chk(1'b0, "pop_when_empty", g, 0);
        else
          fd[g] <= fq[g].pop_front();
      end
      fe[g] <= (fq[g].size() == 0);
    end
  end

  // Monitor: decode frames and compare.
  always @(negedge clk) begin : mon
    logic [7:0] b;
    int         bp;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        cap[g] = 1'b0;
      end else begin
        if (rd_w[g]) last_rd[g] = cyc;
        if (!cap[g] && bd_w[g])
          chk(1'b0, "stray_byte_done", g, 0);
        if (!cap[g] && !tx_w[g]) begin
          b = 8'h00;
          if (eq[g].size() != 0)
            b = eq[g].pop_front();
          else
            chk(1'b0, "unexpected_frame", g, 0);
          expv[g]  = frame_of(b, g);
          nbits[g] = (g == 0) ? 10 : 11;
          cap[g]   = 1'b1;
          idx[g]   = 0;
          bad[g]   = 1'b0;
          bdc[g]   = 0;
          gotv[g]  = '0;
          chk(cyc - last_rd[g] == 2,
              "start_latency",
              cyc - last_rd[g], 2);
          if (g == 0) st0.push_back(cyc);
        end
        if (cap[g]) begin
          bp = idx[g] / C;
          if (idx[g] % C == 0)
            gotv[g][bp] = tx_w[g];
          else if (tx_w[g] != gotv[g][bp])
            bad[g] = 1'b1;
          if (bd_w[g]) bdc[g]++;
          if (idx[g] == nbits[g] * C - 1) begin
            chk(!bad[g] && gotv[g] == expv[g],
                "frame", gotv[g], expv[g]);
            chk(bd_w[g] && bdc[g] == 1,
                "byte_done", bdc[g], 1);
            done_cnt[g]++;
            if (g == 0) en0.push_back(cyc);
            cap[g] = 1'b0;
          end else begin
            idx[g]++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(
    input int         g,
    input logic [7:0] b
  );
    fq[g].push_back(b);
    eq[g].push_back(b);
  endtask

  task automatic wait_done(
    input int g,
    input int tgt,
    input int budget
  );
    for (int i = 0; i < budget; i++) begin
      if (done_cnt[g] >= tgt) break;
      step(1);
    end
    chk(done_cnt[g] >= tgt, "done_timeout",
        done_cnt[g], tgt);
  endtask

  task automatic wait_start(
    input int tgt,
    input int budget
  );
    for (int i = 0; i < budget; i++) begin
      if (st0.size() >= tgt) break;
      step(1);
    end
    chk(st0.size() >= tgt, "start_timeout",
        st0.size(), tgt);
  endtask

  initial begin
    int s;
    int p;
    int base;
    int viol;
    int gap;

    // Reset state
    step(3);
    for (int g = 0; g < 3; g++) begin
      chk(tx_w[g] == 1'b1, "reset_tx", tx_w[g], 1);
      chk(busy_w[g] == 1'b0, "reset_busy",
          busy_w[g], 0);
      chk(rd_w[g] == 1'b0, "reset_rd_en",
          rd_w[g], 0);
      chk(bd_w[g] == 1'b0, "reset_byte_done",
          bd_w[g], 0);
    end
    rst_n = 1'b1;
    step(2);

    // Single byte, no parity
    tx_en = 1'b1;
    push(0, 8'hA5);
    wait_done(0, 1, 200);
    chk(pops[0] == 1, "t1_pops", pops[0], 1);
    chk(busy_w[0] == 1'b0, "t1_busy_fall",
        busy_w[0], 0);

    // Parity, even and odd
    push(1, 8'h07);
    push(2, 8'h07);
    wait_done(1, 1, 300);
    wait_done(2, 1, 300);
    chk(pops[1] == 1, "t2_pops_even", pops[1], 1);
    chk(pops[2] == 1, "t2_pops_odd", pops[2], 1);

    // Back-to-back frames
    base = done_cnt[0];
    p    = pops[0];
    s    = st0.size();
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    wait_done(0, base + 3, 600);
    chk(pops[0] - p == 3, "t3_pops", pops[0] - p, 3);
    chk(st0.size() >= s + 3 && en0.size() >= s + 3,
        "t3_frames", st0.size() - s, 3);
    for (int k = 0; k < 2; k++) begin
      if (st0.size() > s + k + 1 &&
          en0.size() > s + k) begin
        gap = st0[s + k + 1] - en0[s + k] - 1;
        chk(gap == 2, "t3_gap", gap, 2);
      end
    end
    step(3);
    chk(busy_w[0] == 1'b0 && fe[0] == 1'b1,
        "t3_idle", busy_w[0], 0);

    // tx_en low holds off, mid-frame drop
    tx_en = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h5A);
    p    = pops[0];
    viol = 0;
    repeat (100) begin
      step(1);
      if (rd_w[0] || !tx_w[0] || busy_w[0]) viol++;
    end
    chk(viol == 0, "t4_hold", viol, 0);
    base  = done_cnt[0];
    s     = st0.size();
    tx_en = 1'b1;
    wait_start(s + 1, 50);
    step(4 * C);
    tx_en = 1'b0;
    wait_done(0, base + 1, 200);
    step(60);
    chk(pops[0] - p == 1, "t4_one_pop",
        pops[0] - p, 1);
    chk(fq[0].size() == 1, "t4_fifo_left",
        fq[0].size(), 1);

    // Reset during data bit 3
    base  = done_cnt[0];
    s     = st0.size();
    tx_en = 1'b1;
    wait_start(s + 1, 50);
    step(17);
    rst_n = 1'b0;
    #1;
    chk(tx_w[0] == 1'b1, "t5_tx_high", tx_w[0], 1);
    chk(busy_w[0] == 1'b0, "t5_busy_low",
        busy_w[0], 0);
    p = pops[0];
    push(0, 8'hC3);
    step(3);
    rst_n = 1'b1;
    wait_done(0, base + 1, 200);
    chk(pops[0] - p == 1, "t5_repop", pops[0] - p, 1);

    // Empty FIFO throughout
    step(5);
    viol = 0;
    repeat (150) begin
      step(1);
      for (int g = 0; g < 3; g++)
        if (rd_w[g] || !tx_w[g] || bd_w[g]) viol++;
    end
    chk(viol == 0, "t6_quiet", viol, 0);
    chk(eq[0].size() + eq[1].size() +
        eq[2].size() == 0, "sb_drained",
        eq[0].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
